vld_elem_sequencer: RTL
=======================

// Module: vld_elem_sequencer
// PURPOSE
// - Vector strided-load sequencer feeding the VRF element write port (el_wr_*).
// - Accepts one load (vd, base, stride, vl, mask), issues one 32-bit memory read per active element,
//   takes in-order responses and writes each word into element slot idx of register vd.
// - Sits between vector issue/memory interface (upstream) and the vector register file (downstream).
// PARAMETERS
// - ELEMENTS   8  32-bit elements per vector register
// - MAX_OUTST  4  max memory reads in flight (power of 2, >=1)
// - VLW        $clog2(ELEMENTS+1)  width of req_vl (derived, not overridable)
// PORTS
// - clk            in   1            clock
// - rst_n          in   1            synchronous active-low reset
// - req_valid      in   1            load request valid
// - req_ready      out  1            high only in IDLE
// - req_vd         in   5            destination vector register
// - req_base       in   32           byte address of element 0
// - req_stride     in   32           byte stride between elements (two's complement)
// - req_vl         in   VLW          active length; values >ELEMENTS clamp to ELEMENTS
// - req_mask       in   ELEMENTS     per-element enable (bit0 of each mask-register element)
// - mem_req_valid  out  1            read request valid
// - mem_req_ready  in   1            memory accepts request
// - mem_req_addr   out  32           read byte address
// - mem_rsp_valid  in   1            read data valid (in order, no backpressure)
// - mem_rsp_data   in   32           read data
// - el_wr_en       out  ELEMENTS     one-hot element write enable to VRF
// - el_wr_addr     out  5            VRF register address (= latched vd)
// - el_wr_data     out  ELEMENTS*32  write data; only selected lane meaningful, others 0
// - busy           out  1            high when state != IDLE
// - done           out  1            one-cycle pulse at end of each load
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except req_ready=1; counters, index FIFO cleared.
// - Element i active iff i < clamp(vl) and mask[i]=1; inactive elements get no read and no write.
// - Request accepted on req_valid & req_ready; all req_* latched that cycle; state -> ISSUE.
// - ISSUE: mem_req_valid=1 while a next active element exists and outst < MAX_OUTST;
//   mem_req_addr = base + i*stride (mod 2^32), ascending i. Handshake on valid&ready:
//   push i into index FIFO, advance to next active index. Valid/addr stable until accepted.
// - outst: +1 on request handshake, -1 on mem_rsp_valid; both same cycle -> unchanged.
//   Issue gating uses the registered outst (no same-cycle credit from a response).
// - Response: pop FIFO index j; next cycle el_wr_en=1<<j, el_wr_addr=vd,
//   el_wr_data[32j+:32]=mem_rsp_data, other lanes 0. Write latency exactly 1 cycle.
// - mem_rsp_valid when outst==0 (incl. after reset): ignored, no write, no counter change.
// - ISSUE -> DRAIN once last active element issued; DRAIN -> FIN when outst==0 and FIFO empty.
// - FIN: done=1 for one cycle (cycle after last el_wr_en), then IDLE; req_ready=1 again.
// - No active elements (vl==0 or mask&range==0): ISSUE -> FIN directly, zero memory/VRF traffic;
//   done pulses 2 cycles after accept.
// - Reset mid-operation: abandons load; in-flight responses then ignored per rule above.
// TESTING
// - vd=3, base=0x1000, stride=4, vl=8, mask=0xFF, ready=1, 2-cycle rsp -> addrs 0x1000..0x101C,
//   8 writes reg 3, el_wr_en 0x01..0x80 in order, one done.
// - mask=0xA5, vl=8, stride=8, base=0x2000 -> reads only 0x2000,0x2010,0x2028,0x2038;
//   writes lanes 0,2,5,7 only.
// - vl=0 or mask=0x00 -> no mem_req_valid, no el_wr_en, done 2 cycles after accept.
// - Responses withheld, MAX_OUTST=4, vl=8 -> exactly 4 requests then valid stays 0;
//   each response releases one request.
// - stride=0xFFFFFFFC, base=0x0 -> addrs 0x0,0xFFFFFFFC,0xFFFFFFF8 (wrap);
//   mem_req_ready toggled -> addr held until accepted.
// - rst_n low with 2 reads in flight -> IDLE, outputs 0; late responses cause no el_wr_en.

Source files
------------

// File: rtl/vld_elem_sequencer.sv
// Vector strided-load sequencer: issues one 32-bit read per active element and
// writes each in-order response into its element slot of the destination VRF register.
module vld_elem_sequencer #(
  parameter  int unsigned ELEMENTS  = 8,
  parameter  int unsigned MAX_OUTST = 4,
  localparam int unsigned VLW       = $clog2(ELEMENTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_vd,
  input  logic [31:0]              req_base,
  input  logic [31:0]              req_stride,
  input  logic [VLW-1:0]           req_vl,
  input  logic [ELEMENTS-1:0]      req_mask,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [31:0]              mem_rsp_data,
  output logic [ELEMENTS-1:0]      el_wr_en,
  output logic [4:0]               el_wr_addr,
  output logic [ELEMENTS*32-1:0]   el_wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IW = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]  OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [VLW-1:0] VL_MAX    = VLW'(ELEMENTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [4:0]          vd_q;
  logic [31:0]         base_q;
  logic [31:0]         stride_q;
  logic [ELEMENTS-1:0] pend_q, pend_d;
  logic [OW-1:0]       outst_q, outst_d;

  logic [IW-1:0]       fifo_q [MAX_OUTST];
  logic [PW-1:0]       wptr_q, rptr_q;

  logic [ELEMENTS-1:0]    wr_en_q, wr_en_d;
  logic [4:0]             wr_addr_q, wr_addr_d;
  logic [ELEMENTS*32-1:0] wr_data_q, wr_data_d;

  logic                accept;
  logic                issue_ok;
  logic                req_hs;
  logic                rsp_take;
  logic [VLW-1:0]      vl_clamp;
  logic [ELEMENTS-1:0] act_mask;
  logic [ELEMENTS-1:0] nxt_oh;
  logic [IW-1:0]       nxt_idx;
  logic [IW-1:0]       rsp_idx;
  logic [31:0]         offset;

  // Active elements: inside the clamped vector length and enabled by the mask.
  always_comb begin
    vl_clamp = (req_vl > VL_MAX) ? VL_MAX : req_vl;
    act_mask = '0;
    for (int unsigned i = 0; i < ELEMENTS; i++) begin
      act_mask[i] = req_mask[i] && (VLW'(i) < vl_clamp);
    end
  end

  // Lowest pending element is the next one to issue (ascending order).
  always_comb begin
    nxt_idx = '0;
    for (int unsigned i = ELEMENTS; i > 0; i--) begin
      if (pend_q[i-1]) begin
        nxt_idx = IW'(i - 1);
      end
    end
    nxt_oh = pend_q & (~pend_q + 1'b1);
  end

  assign accept   = req_valid && (state_q == S_IDLE);
  assign issue_ok = (state_q == S_ISSUE) && (pend_q != '0) && (outst_q < OUTST_MAX);
  assign req_hs   = issue_ok && mem_req_ready;
  assign rsp_take = mem_rsp_valid && (outst_q != '0);
  assign rsp_idx  = fifo_q[rptr_q];
  assign offset   = 32'(nxt_idx) * stride_q;

  assign mem_req_valid = issue_ok;
  assign mem_req_addr  = issue_ok ? (base_q + offset) : '0;
  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
  assign el_wr_en      = wr_en_q;
  assign el_wr_addr    = wr_addr_q;
  assign el_wr_data    = wr_data_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          pend_d  = act_mask;
        end
      end
      S_ISSUE: begin
        if (pend_q == '0) begin
          state_d = S_FIN;
        end else if (req_hs) begin
          pend_d = pend_q & ~nxt_oh;
          if ((pend_q & ~nxt_oh) == '0) begin
            state_d = S_DRAIN;
          end
        end
      end
      // The index FIFO holds exactly one entry per outstanding read, so
      // outst_q == 0 also means the FIFO is empty.
      S_DRAIN: begin
        if (outst_q == '0) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({req_hs, rsp_take})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (rsp_take) begin
      wr_addr_d = vd_q;
      for (int unsigned i = 0; i < ELEMENTS; i++) begin
        if (rsp_idx == IW'(i)) begin
          wr_en_d[i]          = 1'b1;
          wr_data_d[32*i +: 32] = mem_rsp_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vd_q      <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      pend_q    <= '0;
      outst_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      outst_q   <= outst_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (accept) begin
        vd_q     <= req_vd;
        base_q   <= req_base;
        stride_q <= req_stride;
      end
      if (req_hs) begin
        fifo_q[wptr_q] <= nxt_idx;
        wptr_q         <= (MAX_OUTST == 1) ? '0 : wptr_q + 1'b1;
      end
      if (rsp_take) begin
        rptr_q <= (MAX_OUTST == 1) ? '0 : rptr_q + 1'b1;
      end
    end
  end

endmodule
